// File: rtl/multi_sink.sv
// Multi-channel capture into a shared FIFO: round-robin grant among ready channels,
// one-cycle read acknowledge per capture, first-word-fall-through head.
module multi_sink #(
    parameter int unsigned WIDTH    = 11,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DEPTH    = 8,
    localparam int unsigned CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int unsigned CNTW    = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       rready,
    input  logic [CHANNELS*WIDTH-1:0] in,
    output logic [CHANNELS-1:0]       read,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_value,
    output logic [CW-1:0]             out_chan,
    input  logic                      pop,
    output logic [CNTW-1:0]           count
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [CW-1:0]       ptr_q, ptr_d;
    logic [PW-1:0]       head_q, head_d;
    logic [PW-1:0]       tail_q, tail_d;
    logic [CNTW-1:0]     count_q, count_d;
    logic [CHANNELS-1:0] read_q, read_d;

    logic [WIDTH-1:0]    data_mem [DEPTH];
    logic [CW-1:0]       chan_mem [DEPTH];

    logic                full;
    logic                do_pop;
    logic [CHANNELS-1:0] eligible;
    logic                grant;
    logic [CW-1:0]       gnt_idx;

    // Fullness is judged on the registered count, so a same-cycle pop cannot open a slot.
    assign full     = (count_q == CNTW'(DEPTH));
    assign do_pop   = pop && (count_q != '0);
    assign eligible = rready & ~read_q & {CHANNELS{~full}};

    always_comb begin
        logic [CW:0] sum;
        grant   = 1'b0;
        gnt_idx = '0;
        sum     = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            sum = {1'b0, ptr_q} + (CW + 1)'(k);
            if (sum >= (CW + 1)'(CHANNELS)) begin
                sum = sum - (CW + 1)'(CHANNELS);
            end
            if (!grant && eligible[CW'(sum)]) begin
                grant   = 1'b1;
                gnt_idx = CW'(sum);
            end
        end
    end

    always_comb begin
        logic [CW:0] nxt;
        nxt     = {1'b0, gnt_idx} + (CW + 1)'(1);
        ptr_d   = ptr_q;
        read_d  = '0;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (grant) begin
            ptr_d  = (nxt == (CW + 1)'(CHANNELS)) ? '0 : CW'(nxt);
            read_d = CHANNELS'(1) << gnt_idx;
            tail_d = (tail_q == PW'(DEPTH - 1)) ? '0 : tail_q + PW'(1);
        end
        if (do_pop) begin
            head_d = (head_q == PW'(DEPTH - 1)) ? '0 : head_q + PW'(1);
        end
        if (grant && !do_pop) begin
            count_d = count_q + CNTW'(1);
        end else if (!grant && do_pop) begin
            count_d = count_q - CNTW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            read_q  <= '0;
        end else begin
            ptr_q   <= ptr_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            read_q  <= read_d;
        end
    end

    // Storage needs no reset: contents are only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (grant) begin
            data_mem[tail_q] <= in[gnt_idx*WIDTH +: WIDTH];
            chan_mem[tail_q] <= gnt_idx;
        end
    end

    assign read      = read_q;
    assign count     = count_q;
    assign out_valid = (count_q != '0);
    assign out_value = data_mem[head_q];
    assign out_chan  = chan_mem[head_q];

endmodule

// File: tb/tb_multi_sink.sv
// Bench for multi_sink: directed vector table, hand-written corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_multi_sink;

    localparam int W  = 11;
    localparam int CH = 4;
    localparam int D  = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [CH-1:0]   rready_v = '0;
    logic [CH*W-1:0] in_v = '0;
    logic            pop_v = 1'b0;
    logic [CH-1:0]   read;
    logic            out_valid;
    logic [W-1:0]    out_value;
    logic [1:0]      out_chan;
    logic [3:0]      count;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        int chan;
        int val;
    } item_t;

    item_t         m_q[$];
    int            m_ptr = 0;
    logic [CH-1:0] m_read = '0;

    typedef struct {
        logic [CH-1:0] rready;
        int            dbase;
        logic          pop;
        logic [CH-1:0] exp_read;
        int            exp_count;
        logic          exp_valid;
        int            exp_value;
        int            exp_chan;
    } vec_t;

    vec_t vecs[$];

    multi_sink #(.WIDTH(W), .CHANNELS(CH), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .rready    (rready_v),
        .in        (in_v),
        .read      (read),
        .out_valid (out_valid),
        .out_value (out_value),
        .out_chan  (out_chan),
        .pop       (pop_v),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic set_in(input int base);
        for (int i = 0; i < CH; i++) in_v[i*W +: W] = W'(base + i);
    endtask

    task automatic model_clear();
        m_q.delete();
        m_ptr  = 0;
        m_read = '0;
    endtask

    // Reference: apply one clock edge worth of the arbitration and FIFO rules.
    task automatic model_edge();
        int    g;
        int    c;
        item_t it;
        g = -1;
        if (m_q.size() < D) begin
            for (int k = 0; k < CH; k++) begin
                c = (m_ptr + k) % CH;
                if (g < 0 && rready_v[c] && !m_read[c]) g = c;
            end
        end
        if (pop_v && m_q.size() > 0) m_q.delete(0);
        if (g >= 0) begin
            it.chan = g;
            it.val  = int'(in_v[g*W +: W]);
            m_q.push_back(it);
            m_read = CH'(1) << g;
            m_ptr  = (g + 1) % CH;
        end else begin
            m_read = '0;
        end
    endtask

    task automatic model_chk();
        chk("m_read", 32'(read), 32'(m_read));
        chk("m_count", 32'(count), m_q.size());
        chk("m_valid", 32'(out_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            chk("m_value", 32'(out_value), m_q[0].val);
            chk("m_chan", 32'(out_chan), m_q[0].chan);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        model_chk();
    endtask

    task automatic reset_mid();
        #3;
        rst = 1'b1;
        #1;
        chk("rst_read", 32'(read), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_valid", 32'(out_valid), 0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        vec_t          v;
        logic [CH-1:0] ord_hot;
        int            rr_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int            drain_ch[8] = '{1, 2, 3, 0, 1, 2, 3, 0};

        // Single word, cooldown, then grant-with-pop across a short queue.
        vecs.push_back('{4'b0100, 997, 1'b0, 4'b0100, 1, 1'b1, 999, 2});
        vecs.push_back('{4'b0000, 0,   1'b0, 4'b0000, 1, 1'b1, 999, 2});
        vecs.push_back('{4'b0000, 0,   1'b1, 4'b0000, 0, 1'b0, 0,   0});
        vecs.push_back('{4'b0000, 0,   1'b1, 4'b0000, 0, 1'b0, 0,   0});
        vecs.push_back('{4'b0010, 100, 1'b0, 4'b0010, 1, 1'b1, 101, 1});
        vecs.push_back('{4'b0010, 300, 1'b0, 4'b0000, 1, 1'b1, 101, 1});
        vecs.push_back('{4'b0010, 110, 1'b0, 4'b0010, 2, 1'b1, 101, 1});
        vecs.push_back('{4'b0010, 300, 1'b0, 4'b0000, 2, 1'b1, 101, 1});
        vecs.push_back('{4'b0010, 120, 1'b0, 4'b0010, 3, 1'b1, 101, 1});
        vecs.push_back('{4'b0010, 300, 1'b0, 4'b0000, 3, 1'b1, 101, 1});
        vecs.push_back('{4'b0010, 200, 1'b1, 4'b0010, 3, 1'b1, 111, 1});
        vecs.push_back('{4'b0000, 0,   1'b1, 4'b0000, 2, 1'b1, 121, 1});
        vecs.push_back('{4'b0000, 0,   1'b1, 4'b0000, 1, 1'b1, 201, 1});
        vecs.push_back('{4'b0000, 0,   1'b1, 4'b0000, 0, 1'b0, 0,   0});

        #12;
        chk("reset_read", 32'(read), 0);
        chk("reset_count", 32'(count), 0);
        chk("reset_valid", 32'(out_valid), 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            v = vecs[i];
            rready_v = v.rready;
            set_in(v.dbase);
            pop_v = v.pop;
            step();
            chk($sformatf("vec%0d_read", i), 32'(read), 32'(v.exp_read));
            chk($sformatf("vec%0d_count", i), 32'(count), v.exp_count);
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(v.exp_valid));
            if (v.exp_valid) begin
                chk($sformatf("vec%0d_value", i), 32'(out_value), v.exp_value);
                chk($sformatf("vec%0d_chan", i), 32'(out_chan), v.exp_chan);
            end
        end
        rready_v = '0;
        pop_v    = 1'b0;
        reset_mid();

        // Round-robin fill from ptr=0 until full.
        rready_v = 4'b1111;
        set_in(50);
        for (int k = 0; k < 10; k++) begin
            step();
            ord_hot = (k < 8) ? (CH'(1) << rr_order[k]) : '0;
            chk($sformatf("rr%0d_read", k), 32'(read), 32'(ord_hot));
            chk($sformatf("rr%0d_count", k), 32'(count), (k < 8) ? k + 1 : 8);
        end

        // Pop while full must not unlock a grant in the same cycle.
        rready_v = 4'b0001;
        pop_v    = 1'b1;
        step();
        chk("fullpop_read", 32'(read), 0);
        chk("fullpop_count", 32'(count), 7);
        pop_v = 1'b0;
        step();
        chk("fullpop_next_read", 32'(read), 32'(4'b0001));
        chk("fullpop_next_count", 32'(count), 8);

        rready_v = '0;
        pop_v    = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("drain%0d_chan", k), 32'(out_chan), drain_ch[k]);
            step();
        end
        pop_v = 1'b0;

        // Build count=5 with read[3] high, then reset between edges.
        rready_v = 4'b0001; step();
        rready_v = 4'b0000; step();
        rready_v = 4'b0001; step();
        rready_v = 4'b1110;
        for (int k = 0; k < 3; k++) step();
        chk("pre_rst_count", 32'(count), 5);
        chk("pre_rst_read", 32'(read), 32'(4'b1000));
        reset_mid();
        rready_v = 4'b1100;
        step();
        chk("post_rst_grant", 32'(read), 32'(4'b0100));

        // Randomized traffic with alternating fill/drain bias.
        for (int k = 0; k < 3000; k++) begin
            rready_v = CH'($urandom);
            in_v     = {$urandom, $urandom};
            if ((k / 150) % 2 == 0) pop_v = ($urandom_range(0, 3) == 0);
            else                    pop_v = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
